oam_dma: RTL and testbench

OAM DMA initiator for the Game Boy memory map. A CPU write to the DMA register at 0xFF46 starts a copy of 160 bytes from `{value,8'h00}`–`{value,8'h9F}` into OAM at 0xFE00–0xFE9F. The block is a bus master, so the graphics peripheral sees the copy as ordinary OAM writes. While the copy runs, `busy` is raised so the bus arbiter can hold CPU accesses outside HRAM.

---
 rtl/oam_dma_if.sv | 29 ++
 rtl/oam_dma.sv | 159 +++++++++++++++
 tb/tb_oam_dma.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// Master-side memory bus used by the OAM DMA engine.
// The engine is the master: it issues read beats from the source page and
// write beats into OAM. The arbiter/memory side is the slave.
interface oam_dma_if;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_gnt;
  logic [7:0]  m_rdata;

  modport master (
    output m_req,
    output m_we,
    output m_addr,
    output m_wdata,
    input  m_gnt,
    input  m_rdata
  );

  modport slave (
    input  m_req,
    input  m_we,
    input  m_addr,
    input  m_wdata,
    output m_gnt,
    output m_rdata
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA initiator for the Game Boy memory map.
// A CPU write to DMA_ADDR latches the source page and copies XFER_LEN bytes
// from {page,00}.. into OAM_BASE.. through the master bus, one read beat,
// one capture cycle and one write beat per byte. A new write to DMA_ADDR
// abandons any running copy and restarts from index 0.
// Optional feature macro: OAM_DMA_READBACK_EN -- when defined, CPU reads of
// DMA_ADDR return the latched source page; otherwise they return 8'hFF.
module oam_dma #(
  parameter logic [15:0] DMA_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter int          XFER_LEN = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [7:0]       cpu_wdata,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_rd_en,
  oam_dma_if.master        bus,
  output logic             busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_CAPTURE,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  src_hi_q, src_hi_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rd_en_q, cpu_rd_en_d;

  logic        dma_wr;
  logic        dma_rd;

  logic        m_req_c;
  logic        m_we_c;
  logic [15:0] m_addr_c;
  logic [7:0]  m_wdata_c;

  assign dma_wr = cpu_we && (cpu_addr == DMA_ADDR);
  assign dma_rd = cpu_re && (cpu_addr == DMA_ADDR);

  // Register update; reset wins over a CPU write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_hi_q    <= 8'h00;
      idx_q       <= 8'h00;
      data_q      <= 8'h00;
      cpu_rdata_q <= 8'h00;
      cpu_rd_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_hi_q    <= src_hi_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_rd_en_q <= cpu_rd_en_d;
    end
  end

  // Copy sequencer: a DMA register write overrides whatever the FSM was doing.
  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    data_d   = data_q;

    case (state_q)
      S_START: begin
        state_d = S_READ;
      end
      S_READ: begin
        if (bus.m_gnt) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        data_d  = bus.m_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.m_gnt) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (dma_wr) begin
      src_hi_d = cpu_wdata;
      idx_d    = 8'h00;
      state_d  = S_START;
    end
  end

  // CPU register read port, answered one cycle after the strobe.
  always_comb begin
    cpu_rd_en_d = dma_rd;
    cpu_rdata_d = 8'h00;
    if (dma_rd) begin
`ifdef OAM_DMA_READBACK_EN
      cpu_rdata_d = src_hi_q;
`else
      cpu_rdata_d = 8'hFF;
`endif
    end
  end

  // Bus outputs decoded purely from registered state, so they hold steady while stalled.
  always_comb begin
    m_req_c   = 1'b0;
    m_we_c    = 1'b0;
    m_addr_c  = 16'h0000;
    m_wdata_c = 8'h00;
    case (state_q)
      S_READ: begin
        m_req_c  = 1'b1;
        m_addr_c = {src_hi_q, idx_q};
      end
      S_WRITE: begin
        m_req_c   = 1'b1;
        m_we_c    = 1'b1;
        m_addr_c  = OAM_BASE + {8'h00, idx_q};
        m_wdata_c = data_q;
      end
      default: begin
        m_req_c = 1'b0;
      end
    endcase
  end

  assign bus.m_req   = m_req_c;
  assign bus.m_we    = m_we_c;
  assign bus.m_addr  = m_addr_c;
  assign bus.m_wdata = m_wdata_c;

  assign busy      = (state_q != S_IDLE);
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_rd_en = cpu_rd_en_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma. A behavioural model describes each copy as
// the list of bus beats it must produce (read {page,i}, write OAM_BASE+i with
// the source byte) and a source-memory array answers read beats.
`timescale 1ns/1ps
module tb_oam_dma;

  localparam logic [15:0] DMA_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam int          XFER_LEN = 160;
`ifdef OAM_DMA_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rd_en;
  logic        busy;

  oam_dma_if bus_if ();

  oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rd_en (cpu_rd_en),
    .bus       (bus_if),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:XFER_LEN-1];
  beat_t      exp_q[$];
  int         exp_idx = 0;
  int         total = 0;
  int         bad = 0;
  int         beat_count = 0;
  int         write_count = 0;
  int         busy_cycles = 0;
  int         gnt_mode = 0;
  int         stall_cnt = 0;
  int         stall_beat = -1;
  bit         exp_rd_en = 1'b0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] model_src_hi = 8'h00;

  // Single comparison point: counts it and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model of one complete copy from source page src.
  task automatic buildExpected(input logic [7:0] src);
    beat_t b;
    exp_q.delete();
    exp_idx = 0;
    for (int i = 0; i < XFER_LEN; i++) begin
      b.we   = 1'b0;
      b.addr = {src, 8'(i)};
      b.data = 8'h00;
      exp_q.push_back(b);
      b.we   = 1'b1;
      b.addr = OAM_BASE + 16'(i);
      b.data = mem[{src, 8'(i)}];
      exp_q.push_back(b);
    end
  endtask

  // Fill OAM with values guaranteed to differ from the coming copy.
  task automatic prepOam(input logic [7:0] src);
    for (int i = 0; i < XFER_LEN; i++) oam[i] = ~mem[{src, 8'(i)}];
  endtask

  task automatic checkOam(input logic [7:0] src);
    for (int i = 0; i < XFER_LEN; i++) checkOutput("oam_byte", oam[i], mem[{src, 8'(i)}]);
  endtask

  // One clock cycle: drive CPU inputs and grant, then check and log the bus.
  task automatic applyStimulus(input bit rst_v, input bit we_v, input bit re_v,
                               input logic [15:0] addr_v, input logic [7:0] wd_v);
    beat_t e;
    bit    g;
    @(posedge clk);
    #1;
    reset     = rst_v;
    cpu_we    = we_v;
    cpu_re    = re_v;
    cpu_addr  = addr_v;
    cpu_wdata = wd_v;

    checkOutput("cpu_rd_en", cpu_rd_en, exp_rd_en);
    if (exp_rd_en) checkOutput("cpu_rdata", cpu_rdata, exp_rdata);

    g = 1'b1;
    case (gnt_mode)
      1: begin
        if (bus_if.m_req) begin
          if (stall_cnt == 0 && (beat_count % 4) == 3 && stall_beat != beat_count) begin
            stall_cnt  = 3;
            stall_beat = beat_count;
          end
          if (stall_cnt > 0) begin
            g = 1'b0;
            stall_cnt--;
          end
        end
      end
      2: g = ($urandom_range(0, 3) != 0);
      3: g = !bus_if.m_we;
      default: g = 1'b1;
    endcase
    bus_if.m_gnt = g;

    if (bus_if.m_req) begin
      checkOutput("busy_with_req", busy, 1);
      if (exp_idx < exp_q.size()) begin
        e = exp_q[exp_idx];
        checkOutput("m_we", bus_if.m_we, e.we);
        checkOutput("m_addr", bus_if.m_addr, e.addr);
        if (e.we) checkOutput("m_wdata", bus_if.m_wdata, e.data);
      end else begin
        checkOutput("unexpected_req", bus_if.m_req, 0);
      end
      if (g) begin
        beat_count++;
        exp_idx++;
        if (!bus_if.m_we) begin
          bus_if.m_rdata = mem[bus_if.m_addr];
        end else begin
          write_count++;
          if (bus_if.m_addr >= OAM_BASE && bus_if.m_addr < OAM_BASE + 16'(XFER_LEN))
            oam[bus_if.m_addr - OAM_BASE] = bus_if.m_wdata;
        end
      end
    end

    exp_rd_en = !rst_v && re_v && (addr_v == DMA_ADDR);
    exp_rdata = READBACK ? model_src_hi : 8'hFF;
    if (rst_v) begin
      model_src_hi = 8'h00;
      exp_q.delete();
      exp_idx = 0;
    end else if (we_v && addr_v == DMA_ADDR) begin
      model_src_hi = wd_v;
      buildExpected(wd_v);
    end
  endtask

  // Idle the CPU until busy drops, counting busy cycles, with a cycle budget.
  task automatic runToIdle(input int max_cycles);
    int n;
    n = 0;
    while (1) begin
      applyStimulus(0, 0, 0, 16'h0000, 8'h00);
      if (!busy) break;
      busy_cycles++;
      n++;
      if (n >= max_cycles) begin
        checkOutput("run_timeout", busy, 0);
        break;
      end
    end
    checkOutput("beats_done", exp_idx, exp_q.size());
  endtask

  initial begin
    logic [7:0] rsrc;
    int         n;
    int         beats_before;

    bus_if.m_gnt   = 1'b0;
    bus_if.m_rdata = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < XFER_LEN; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;

    $display("[TB] reset and idle");
    applyStimulus(1, 0, 0, 16'h0000, 8'h00);
    applyStimulus(1, 0, 0, 16'h0000, 8'h00);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 0, 16'h0000, 8'h00);
      checkOutput("idle_m_req", bus_if.m_req, 0);
      checkOutput("idle_m_we", bus_if.m_we, 0);
      checkOutput("idle_m_addr", bus_if.m_addr, 0);
      checkOutput("idle_m_wdata", bus_if.m_wdata, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_cpu_rdata", cpu_rdata, 0);
    end

    $display("[TB] copy C0 with grant high");
    gnt_mode = 0;
    prepOam(8'hC0);
    applyStimulus(0, 1, 0, DMA_ADDR, 8'hC0);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_no_req", bus_if.m_req, 0);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("first_req", bus_if.m_req, 1);
    checkOutput("first_addr", bus_if.m_addr, 16'hC000);
    busy_cycles = 2;
    runToIdle(2000);
    checkOutput("busy_cycles", busy_cycles, 481);
    checkOam(8'hC0);

    $display("[TB] copy C0 with periodic stalls");
    gnt_mode   = 1;
    stall_cnt  = 0;
    stall_beat = -1;
    beat_count = 0;
    prepOam(8'hC0);
    applyStimulus(0, 1, 0, DMA_ADDR, 8'hC0);
    busy_cycles = 0;
    runToIdle(4000);
    checkOam(8'hC0);

    $display("[TB] restart after 50 writes");
    gnt_mode = 0;
    prepOam(8'hD0);
    applyStimulus(0, 1, 0, DMA_ADDR, 8'hC0);
    write_count = 0;
    n = 0;
    while (write_count < 50 && n < 1000) begin
      applyStimulus(0, 0, 0, 16'h0000, 8'h00);
      n++;
    end
    checkOutput("fifty_writes", write_count, 50);
    applyStimulus(0, 1, 0, DMA_ADDR, 8'hD0);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("restart_busy", busy, 1);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("restart_addr", bus_if.m_addr, 16'hD000);
    busy_cycles = 2;
    runToIdle(2000);
    checkOutput("restart_busy_cycles", busy_cycles, 481);
    checkOam(8'hD0);

    $display("[TB] reset during stalled write");
    gnt_mode = 3;
    applyStimulus(0, 1, 0, DMA_ADDR, 8'hC0);
    n = 0;
    while (!(bus_if.m_req && bus_if.m_we) && n < 20) begin
      applyStimulus(0, 0, 0, 16'h0000, 8'h00);
      n++;
    end
    checkOutput("reached_write", bus_if.m_we, 1);
    applyStimulus(1, 0, 0, 16'h0000, 8'h00);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("reset_drops_req", bus_if.m_req, 0);
    checkOutput("reset_drops_busy", busy, 0);
    gnt_mode = 0;
    beats_before = beat_count;
    for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("no_beats_after_reset", beat_count, beats_before);

    $display("[TB] reset beats simultaneous write");
    applyStimulus(1, 1, 0, DMA_ADDR, 8'h33);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("rst_prio_busy", busy, 0);
    applyStimulus(0, 0, 1, DMA_ADDR, 8'h00);
    checkOutput("rst_prio_req", bus_if.m_req, 0);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);

    $display("[TB] register readback");
    gnt_mode = 2;
    prepOam(8'h80);
    applyStimulus(0, 1, 0, DMA_ADDR, 8'h80);
    applyStimulus(0, 0, 1, DMA_ADDR, 8'h00);
    applyStimulus(0, 0, 1, DMA_ADDR + 16'd1, 8'h00);
    checkOutput("rd_ff46_en", cpu_rd_en, 1);
    checkOutput("rd_ff46_data", cpu_rdata, READBACK ? 8'h80 : 8'hFF);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    checkOutput("rd_ff47_en", cpu_rd_en, 0);
    busy_cycles = 0;
    runToIdle(4000);
    checkOam(8'h80);

    $display("[TB] random grant, high source page");
    prepOam(8'hE5);
    applyStimulus(0, 1, 0, DMA_ADDR, 8'hE5);
    runToIdle(4000);
    checkOam(8'hE5);

    rsrc = 8'($urandom_range(0, 8'hDF));
    $display("[TB] random grant, page %0h", rsrc);
    prepOam(rsrc);
    applyStimulus(0, 1, 0, DMA_ADDR, rsrc);
    runToIdle(4000);
    checkOam(rsrc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
